// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single shared memory port, with a response watchdog.
// Optional build macro ARB_RR_EN: round-robin on ties instead of fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                timeout_err
);

    // state | meaning
    // IDLE  | waiting for a request, ready offered to the granted requester
    // ISSUE | latched request presented to memory until mem_req_ready
    // WAIT  | waiting for mem_resp_valid or watchdog expiry
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);

    state_t             state;
    state_t             state_nxt;
    logic               grant_lsu;
    logic               grant_ifu;
    logic               accept;
    logic               owner_lsu;
    logic               resp_fire;
    logic               resp_err;
    logic               wd_expire;
    logic [CNT_W-1:0]   wd_cnt;

`ifdef ARB_RR_EN
    logic               last_lsu;

    // On a tie the requester that did not win the previous accept goes first.
    always_comb begin
        grant_lsu = lsu_req_valid;
        if (lsu_req_valid && ifu_req_valid) begin
            grant_lsu = ~last_lsu;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_lsu <= 1'b0;
        end else if (accept) begin
            last_lsu <= grant_lsu;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
    end
`endif

    assign grant_ifu     = ifu_req_valid & ~grant_lsu;
    // Gated by reset so no ready is offered while reset is held.
    assign ifu_req_ready = reset & (state == S_IDLE) & grant_ifu;
    assign lsu_req_ready = reset & (state == S_IDLE) & grant_lsu;
    assign accept        = ifu_req_ready | lsu_req_ready;
    assign mem_req_valid = (state == S_ISSUE);

    always_comb begin
        wd_expire = 1'b0;
        if (TIMEOUT > 0) begin
            wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));
        end
    end

    always_comb begin
        state_nxt = state;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wd_expire) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request payload; IFU fetches are always full-word reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_lsu <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (accept) begin
            owner_lsu <= grant_lsu;
            if (grant_lsu) begin
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
            end else begin
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= {MASK_W{1'b1}};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if ((state == S_ISSUE) && mem_req_ready) begin
            wd_cnt <= '0;
        end else if ((state == S_WAIT) && !mem_resp_valid && !wd_expire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
            timeout_err    <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            if (resp_fire) begin
                if (owner_lsu) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= resp_err ? ERR_DATA : mem_rdata;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= resp_err ? ERR_DATA : mem_rdata;
                end
            end
            if (resp_err) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of transactions plus timeout and async-reset sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic last_lsu = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ifu_v;
        logic [31:0] ifu_a;
        logic        lsu_v;
        logic [31:0] lsu_a;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          stall;
        int          lat;
        logic        junk;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_lsu(input logic iv, input logic lv);
`ifdef ARB_RR_EN
        if (iv && lv) return ~last_lsu;
`endif
        return lv;
    endfunction

    task automatic run_txn(input vec_t v);
        logic        el;
        logic [31:0] ea;
        el = pick_lsu(v.ifu_v, v.lsu_v);
        ea = el ? v.lsu_a : v.ifu_a;
        ifu_req_valid = v.ifu_v;  ifu_addr  = v.ifu_a;
        lsu_req_valid = v.lsu_v;  lsu_addr  = v.lsu_a;
        lsu_wen = v.wen;  lsu_wdata = v.wdata;  lsu_wmask = v.wmask;
        #1;
        check("ifu_req_ready", ifu_req_ready, !el);
        check("lsu_req_ready", lsu_req_ready, el);
        step();
        last_lsu = el;
        check("issue_valid", mem_req_valid, 1'b1);
        check("issue_addr", mem_addr, ea);
        check("issue_wen", mem_wen, el ? v.wen : 1'b0);
        check("issue_wmask", mem_wmask, el ? v.wmask : 4'hF);
        if (el) check("issue_wdata", mem_wdata, v.wdata);
        check("issue_readys", {ifu_req_ready, lsu_req_ready}, 2'b00);
        for (int i = 0; i < v.stall; i++) begin
            step();
            check("stall_valid", mem_req_valid, 1'b1);
            check("stall_addr", mem_addr, ea);
            check("stall_wmask", mem_wmask, el ? v.wmask : 4'hF);
            check("stall_readys", {ifu_req_ready, lsu_req_ready}, 2'b00);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        mem_resp_valid = v.junk;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        for (int i = 0; i < v.lat - 1; i++) begin
            check("wait_quiet", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_rdata = v.rdata;
        step();
        mem_resp_valid = 1'b0;
        check("ifu_resp_valid", ifu_resp_valid, !el);
        check("lsu_resp_valid", lsu_resp_valid, el);
        check("resp_rdata", el ? lsu_rdata : ifu_rdata, v.rdata);
        check("back_idle", mem_req_valid, 1'b0);
        step();
        check("resp_one_pulse", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    endtask

    initial begin
        logic seen;
        int   lats[10];
        lats = '{3, 1, 8, 5, 2, 7, 4, 6, 1, 8};

        vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 2, 1'b0, 32'h0010_0073};
        vecs[1] = '{1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'h3, 0, 1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 3, 1'b1, 32'h0000_0513};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'hF, 5, 4, 1'b1, 32'hCAFE_F00D};
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                vecs[4+i] = '{1'b1, 32'h8000_0100 + 32'(4*i), 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                              i % 3, lats[i], 1'b0, 32'h1000_0000 + 32'(i)};
            else
                vecs[4+i] = '{1'b0, 32'h0, 1'b1, 32'h8000_2000 + 32'(4*i), i[1], 32'h5500_0000 + 32'(i),
                              4'hF >> (i % 4), i % 2, lats[i], lats[i] > 1, 32'h2000_0000 + 32'(i)};
        end
        for (int i = 0; i < 4; i++)
            vecs[14+i] = '{1'b1, 32'h8000_0200 + 32'(4*i), 1'b1, 32'h8000_3000 + 32'(4*i), 1'b1,
                           32'h7700_0000 + 32'(i), 4'hC, 0, 2, 1'b0, 32'hA000_0000 + 32'(i)};

        reset = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        #2;
        check("rst_readys", {ifu_req_ready, lsu_req_ready}, 2'b00);
        check("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        check("rst_rdata", ifu_rdata | lsu_rdata, 32'h0);
        check("rst_mem", {mem_req_valid, mem_wen, mem_wmask}, 6'h0);
        check("rst_mem_addr", mem_addr | mem_wdata, 32'h0);
        check("rst_timeout_err", timeout_err, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 18; i++) run_txn(vecs[i]);

        // Watchdog: IFU fetch never answered.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400;
        #1;
        check("to_ifu_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            step();
            seen = seen | ifu_resp_valid | lsu_resp_valid;
        end
        check("to_no_early_resp", seen, 1'b0);
        check("to_err_before", timeout_err, 1'b0);
        step();
        check("to_ifu_resp", ifu_resp_valid, 1'b1);
        check("to_lsu_resp", lsu_resp_valid, 1'b0);
        check("to_rdata", ifu_rdata, 32'hDEAD_BEEF);
        check("to_err", timeout_err, 1'b1);
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        check("to_pulse_end", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        step();
        mem_resp_valid = 1'b0;
        check("stray_dropped", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        check("stray_rdata", ifu_rdata, 32'hDEAD_BEEF);
        check("err_sticky", timeout_err, 1'b1);
        check("stray_idle", mem_req_valid, 1'b0);

        // Asynchronous reset while waiting for an LSU response.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_5000; lsu_wen = 1'b1;
        lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 4'h1;
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_mem", {mem_req_valid, mem_wen, mem_wmask}, 6'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        check("arst_err", timeout_err, 1'b0);
        check("arst_ifu_rdata", ifu_rdata, 32'h0);
        check("arst_lsu_rdata", lsu_rdata, 32'h0);
        check("arst_readys", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}, 4'h0);
        step();
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h3333_4444;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_resp_valid = 1'b0;
            seen = seen | ifu_resp_valid | lsu_resp_valid | mem_req_valid;
        end
        check("post_reset_quiet", seen, 1'b0);
        check("post_reset_lsu_rdata", lsu_rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
